// File: rtl/max_scan_ctrl.sv
// Host-bus front end for a single-port word buffer with a built-in max/argmax scan sequencer.
// Host buffer writes/reads arbitrate against the scan; only STATUS reads bypass a running scan.
module max_scan_ctrl #(
  parameter int          N_WORDS  = 16,
  parameter logic [31:0] BUF_BASE = 32'h1000_0000,
  parameter logic [31:0] RES_BASE = 32'h2000_0000,
  parameter int          AW       = $clog2(N_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [31:0]   host_addr_i,
  input  logic [31:0]   host_wdata_i,
  output logic          host_ack_o,
  output logic          host_resp_o,
  output logic [31:0]   host_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            BW   = AW + 2;
  localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HRD, SCAN, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic          cmp_vld_q;
  logic [AW-1:0] cmp_idx_q;
  logic [31:0]   run_max_q, run_max_d;
  logic [AW-1:0] run_idx_q, run_idx_d;
  logic [31:0]   max_q, max_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          in_buf, in_res, busy, start, status_rd;
  logic [AW-1:0] word;
  logic [1:0]    reg_off;
  logic [31:0]   reg_val;

  assign in_buf    = (host_addr_i[31:BW] == BUF_BASE[31:BW]);
  assign in_res    = (host_addr_i[31:4] == RES_BASE[31:4]);
  assign word      = host_addr_i[BW-1:2];
  assign reg_off   = host_addr_i[3:2];
  assign busy      = (state_q == SCAN) || (state_q == FIN);
  assign status_rd = host_req_i && !host_we_i && in_res && (reg_off == 2'd2) && !resp_q;

  // Unmapped reads fall through to zero.
  always_comb begin
    reg_val = '0;
    if (in_res) begin
      case (reg_off)
        2'd0:    reg_val = max_q;
        2'd1:    reg_val = {{(32-AW){1'b0}}, idx_q};
        2'd2:    reg_val = {30'b0, valid_q, busy};
        default: reg_val = '0;
      endcase
    end
  end

  // Index 0 seeds the running max; later words replace it only when strictly greater.
  always_comb begin
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if (cmp_vld_q && ((cmp_idx_q == '0) || (mem_rdata_i > run_max_q))) begin
      run_max_d = mem_rdata_i;
      run_idx_d = cmp_idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    max_d       = max_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    resp_d      = 1'b0;
    rdata_d     = '0;
    start       = 1'b0;
    host_ack_o  = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (host_req_i && !resp_q) begin
            host_ack_o = 1'b1;
            if (in_buf) begin
              mem_en_o   = 1'b1;
              mem_addr_o = word;
              if (host_we_i) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = host_wdata_i;
                start       = (word == LAST);
              end else begin
                state_d = HRD;
              end
            end else if (host_we_i) begin
              start = in_res && (reg_off == 2'd3) && host_wdata_i[0];
            end else begin
              resp_d  = 1'b1;
              rdata_d = reg_val;
            end
          end
        end
        HRD: state_d = IDLE;
        SCAN: begin
          mem_en_o   = 1'b1;
          mem_addr_o = scan_addr_q;
          if (scan_addr_q == LAST) state_d = FIN;
          else                     scan_addr_d = scan_addr_q + 1'b1;
        end
        FIN: begin
          state_d = IDLE;
          max_d   = run_max_d;
          idx_d   = run_idx_d;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (busy && status_rd) begin
        host_ack_o = 1'b1;
        resp_d     = 1'b1;
        rdata_d    = reg_val;
      end
      if (start) begin
        state_d     = SCAN;
        scan_addr_d = '0;
        valid_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      scan_addr_q <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      cmp_vld_q   <= (state_q == SCAN);
      cmp_idx_q   <= scan_addr_q;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign host_resp_o  = (state_q == HRD) || resp_q;
  assign host_rdata_o = (state_q == HRD) ? mem_rdata_i : rdata_q;
  assign busy_o       = busy;
  assign done_o       = done_q;

endmodule
